// File: rtl/toggle_evt_pkg.sv
// Shared defaults for the toggle-signalling link (receiver and sender benches).
package toggle_evt_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned PEND_W_DEF      = 4;
    localparam int unsigned CNT_W_DEF       = 16;

endpackage : toggle_evt_pkg

// File: rtl/toggle_event_receiver_sync_chain.sv
// Reset-to-zero shift chain used to sample an asynchronous level into the clk domain.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] s;

    always_ff @(posedge clk) begin
        if (reset) begin
            s <= '0;
        end else begin
            s[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                s[i] <= s[i-1];
            end
        end
    end

    assign q = s[STAGES-1];

endmodule : sync_chain

// File: rtl/toggle_event_receiver.sv
// Toggle-link receiver: detects level changes on tog_in, pulses once per event,
// queues events for a valid/ready consumer, keeps a wrapping total and sticky overflow.
module toggle_event_receiver
    import toggle_evt_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned PEND_W      = PEND_W_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tog_in,
    input  logic              evt_ready,
    input  logic              clr_overflow,
    output logic              evt_pulse,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  total_count,
    output logic              overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic              sync_q;
    logic              prev_level;
    logic              det;
    logic              consume;
    logic [PEND_W-1:0] pending_nxt;
    logic              ovf_set;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (tog_in),
        .q     (sync_q)
    );

    assign det     = sync_q ^ prev_level;
    assign consume = evt_valid & evt_ready;

    // Queue depth update; a simultaneous arrival and drain leaves the depth untouched.
    always_comb begin
        pending_nxt = pending;
        ovf_set     = 1'b0;
        if (det && !consume) begin
            if (pending == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pending_nxt = pending + PEND_W'(1);
            end
        end else if (!det && consume) begin
            pending_nxt = pending - PEND_W'(1);
        end
    end

    // evt_valid is registered alongside pending so it mirrors pending != 0 exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_level  <= 1'b0;
            evt_pulse   <= 1'b0;
            evt_valid   <= 1'b0;
            pending     <= '0;
            total_count <= '0;
            overflow    <= 1'b0;
        end else begin
            prev_level <= sync_q;
            evt_pulse  <= det;
            pending    <= pending_nxt;
            evt_valid  <= (pending_nxt != '0);
            if (det) begin
                total_count <= total_count + CNT_W'(1);
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule : toggle_event_receiver

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver at default parameters.
module tb_toggle_event_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        tog_in;
    logic        evt_ready;
    logic        clr_overflow;
    logic        evt_pulse;
    logic        evt_valid;
    logic [3:0]  pending;
    logic [15:0] total_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    toggle_event_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .tog_in       (tog_in),
        .evt_ready    (evt_ready),
        .clr_overflow (clr_overflow),
        .evt_pulse    (evt_pulse),
        .evt_valid    (evt_valid),
        .pending      (pending),
        .total_count  (total_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic p, input logic v,
                             input logic [3:0] pd, input logic [15:0] tot, input logic ov);
        check({tag, ".pulse"},    32'(evt_pulse),   32'(p));
        check({tag, ".valid"},    32'(evt_valid),   32'(v));
        check({tag, ".pending"},  32'(pending),     32'(pd));
        check({tag, ".total"},    32'(total_count), 32'(tot));
        check({tag, ".overflow"}, 32'(overflow),    32'(ov));
    endtask

    initial begin
        reset        = 1'b1;
        tog_in       = 1'b0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;

        // Reset held 3 cycles while the sender keeps toggling; tog_in ends at 1.
        repeat (3) begin
            tog_in = ~tog_in;
            step(1);
        end
        check_all("reset", 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        reset = 1'b0;
        step(2);
        check("release.no_pulse_yet", 32'(evt_pulse), 32'd0);
        step(1);
        check_all("release.first_event", 1'b1, 1'b1, 4'd1, 16'd1, 1'b0);
        step(1);
        check("release.pulse_one_cycle", 32'(evt_pulse), 32'd0);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check_all("release.drain", 1'b0, 1'b0, 4'd0, 16'd1, 1'b0);

        // Single event 1->0 with consumer stalled, then drained.
        tog_in = ~tog_in;
        step(2);
        check("single.latency", 32'(evt_pulse), 32'd0);
        step(1);
        check_all("single.event", 1'b1, 1'b1, 4'd1, 16'd2, 1'b0);
        step(1);
        check_all("single.hold", 1'b0, 1'b1, 4'd1, 16'd2, 1'b0);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check_all("single.drain", 1'b0, 1'b0, 4'd0, 16'd2, 1'b0);

        // 17 toggles two cycles apart: queue saturates at 15, overflow set.
        repeat (17) begin
            tog_in = ~tog_in;
            step(2);
        end
        step(3);
        check_all("burst.saturate", 1'b0, 1'b1, 4'd15, 16'd19, 1'b1);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        check_all("burst.clear", 1'b0, 1'b1, 4'd15, 16'd19, 1'b0);

        // Arrival and drain on the same edge at saturation: no change, no overflow.
        tog_in = ~tog_in;
        step(2);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check_all("simul.saturated", 1'b1, 1'b1, 4'd15, 16'd20, 1'b0);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check_all("simul.pop", 1'b0, 1'b1, 4'd14, 16'd20, 1'b0);

        // Toggle every cycle until total wraps: 20 + 65516 = 65536 -> 0.
        repeat (65516) begin
            tog_in = ~tog_in;
            step(1);
        end
        check("wrap.pulse_held", 32'(evt_pulse), 32'd1);
        step(3);
        check_all("wrap.total_zero", 1'b0, 1'b1, 4'd15, 16'd0, 1'b1);

        // Glitch high and back between two edges is never sampled.
        tog_in = ~tog_in;
        #3;
        tog_in = ~tog_in;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("glitch.no_pulse", 32'(evt_pulse), 32'd0);
        end
        check_all("glitch.unchanged", 1'b0, 1'b1, 4'd15, 16'd0, 1'b1);

        // Drain to 5, then reset discards the queue and counters.
        evt_ready = 1'b1;
        step(10);
        evt_ready = 1'b0;
        check_all("midreset.pre", 1'b0, 1'b1, 4'd5, 16'd0, 1'b1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_all("midreset.cleared", 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        evt_ready = 1'b1;
        step(2);
        evt_ready = 1'b0;
        check_all("midreset.ready_ignored", 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        tog_in = ~tog_in;
        step(3);
        check_all("midreset.new_event", 1'b1, 1'b1, 4'd1, 16'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_toggle_event_receiver
